// File: rtl/aud_recorder.sv
// Left-channel I2S capture for the WM8731 record path: one 16-bit SRAM write per
// audio frame, with start/pause/stop control and automatic halt when SRAM is full.
module aud_recorder #(
  parameter logic [19:0] ADDR_MAX = 20'hFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lrc,
  input  logic        i_data,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_stop,
  output logic [19:0] o_address,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic [19:0] o_length,
  output logic        o_recording,
  output logic        o_full
);

  typedef enum logic [2:0] {IDLE, WAIT, SHIFT, STORE, PAUSE} state_t;

  // Sample count once the last address is written; clamps if ADDR_MAX+1 overflows 20 bits.
  localparam logic [20:0] LEN_FULL_WIDE = {1'b0, ADDR_MAX} + 21'd1;
  localparam logic [19:0] LEN_FULL      = LEN_FULL_WIDE[20] ? 20'hFFFFF : LEN_FULL_WIDE[19:0];

  state_t      state;
  logic        lrc_q;
  logic        left_edge;
  logic [15:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic        last_write;

  assign left_edge = lrc_q & ~i_lrc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lrc_q <= 1'b0;
    else       lrc_q <= i_lrc;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      last_write  <= 1'b0;
      o_address   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_length    <= '0;
      o_recording <= 1'b0;
      o_full      <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      // The cycle after a strobe commits the write; a start from IDLE below overrides it.
      if (o_valid) begin
        if (last_write) begin
          o_full   <= 1'b1;
          o_length <= LEN_FULL;
        end else begin
          o_address <= o_address + 20'd1;
          o_length  <= o_length + 20'd1;
        end
      end

      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            state       <= WAIT;
            o_recording <= 1'b1;
            o_address   <= '0;
            o_length    <= '0;
            o_full      <= 1'b0;
          end
        end

        WAIT: begin
          if (i_stop) begin
            state       <= IDLE;
            o_recording <= 1'b0;
          end else if (i_pause) begin
            state       <= PAUSE;
            o_recording <= 1'b0;
          end else if (left_edge) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end

        SHIFT: begin
          if (i_stop) begin
            state       <= IDLE;
            o_recording <= 1'b0;
          end else if (i_pause) begin
            state       <= PAUSE;
            o_recording <= 1'b0;
          end else begin
            shift_reg <= {shift_reg[14:0], i_data};
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) state <= STORE;
          end
        end

        // A stop landing here still lets this sample be written and counted.
        STORE: begin
          o_valid    <= 1'b1;
          o_data     <= shift_reg;
          last_write <= (o_address == ADDR_MAX);
          if (i_stop || o_address == ADDR_MAX) begin
            state       <= IDLE;
            o_recording <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end

        PAUSE: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_start) begin
            state       <= WAIT;
            o_recording <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          o_recording <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: I2S frames are driven, expected SRAM writes
// are queued as frames are sent and checked as o_valid strobes appear.
module tb_aud_recorder;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } write_t;

  logic        clk;
  logic        rst;
  logic        lrc;
  logic        data;
  logic        start;
  logic        pause;
  logic        stop;
  logic [19:0] address;
  logic [15:0] wdata;
  logic        valid;
  logic [19:0] length;
  logic        recording;
  logic        full;

  int checks   = 0;
  int failures = 0;
  write_t exp_q[$];

  aud_recorder #(.ADDR_MAX(20'd3)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_lrc       (lrc),
    .i_data      (data),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .o_address   (address),
    .o_data      (wdata),
    .o_valid     (valid),
    .o_length    (length),
    .o_recording (recording),
    .o_full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One control pulse; mask = {stop, pause, start}, driven for a single clock.
  task automatic applyStimulus(input logic [2:0] mask);
    @(negedge clk);
    {stop, pause, start} = mask;
    @(negedge clk);
    {stop, pause, start} = 3'b000;
  endtask

  // One I2S frame (32 BCLK per half, data one bit after the LRC edge).
  // ev_mask = {reset sequence, stop, pause, start}, fired at left-half bit ev_bit.
  task automatic sendFrame(input logic [15:0] left, input logic [15:0] right,
                           input int exp_addr, input int ev_bit, input logic [3:0] ev_mask);
    write_t w;
    if (exp_addr >= 0) begin
      w.addr = exp_addr[19:0];
      w.data = left;
      exp_q.push_back(w);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      lrc  = 1'b0;
      data = (i >= 1 && i <= 16) ? left[16-i] : 1'b0;
      if (!ev_mask[3]) begin
        {stop, pause, start} = (i == ev_bit) ? ev_mask[2:0] : 3'b000;
      end else begin
        start = (i == ev_bit + 4);
        if (i == ev_bit + 2) rst = 1'b0;
        if (i == ev_bit) begin
          #1 rst = 1'b1;
          #1;
          checkOutput("async_rst_valid", {31'd0, valid}, 32'd0);
          checkOutput("async_rst_address", {12'd0, address}, 32'd0);
          checkOutput("async_rst_length", {12'd0, length}, 32'd0);
          checkOutput("async_rst_recording", {31'd0, recording}, 32'd0);
          checkOutput("async_rst_data", {16'd0, wdata}, 32'd0);
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      lrc  = 1'b1;
      data = (i >= 1 && i <= 16) ? right[16-i] : 1'b0;
      {stop, pause, start} = 3'b000;
    end
  endtask

  // Monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (!rst && valid) begin
      checkOutput("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        write_t w;
        w = exp_q.pop_front();
        checkOutput("write_address", {12'd0, address}, {12'd0, w.addr});
        checkOutput("write_data", {16'd0, wdata}, {16'd0, w.data});
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; lrc = 1'b0; data = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_address", {12'd0, address}, 32'd0);
    checkOutput("reset_data", {16'd0, wdata}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_length", {12'd0, length}, 32'd0);
    checkOutput("reset_recording", {31'd0, recording}, 32'd0);
    checkOutput("reset_full", {31'd0, full}, 32'd0);
    rst = 1'b0;
    lrc = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] basic capture");
    applyStimulus(3'b001);
    checkOutput("start_recording", {31'd0, recording}, 32'd1);
    sendFrame(16'hA55A, 16'h0000, 0, -1, 4'b0000);
    sendFrame(16'h8001, 16'h0000, 1, -1, 4'b0000);
    checkOutput("two_frames_length", {12'd0, length}, 32'd2);
    checkOutput("two_frames_address", {12'd0, address}, 32'd2);

    $display("[TB] stop and restart, right channel ignored");
    applyStimulus(3'b100);
    checkOutput("stop_recording", {31'd0, recording}, 32'd0);
    checkOutput("stop_length_hold", {12'd0, length}, 32'd2);
    applyStimulus(3'b001);
    checkOutput("restart_address", {12'd0, address}, 32'd0);
    checkOutput("restart_length", {12'd0, length}, 32'd0);
    sendFrame(16'h0000, 16'hFFFF, 0, -1, 4'b0000);
    sendFrame(16'h0000, 16'hFFFF, 1, -1, 4'b0000);

    $display("[TB] pause mid-frame");
    sendFrame(16'h5A5A, 16'h0000, -1, 8, 4'b0010);
    checkOutput("paused_recording", {31'd0, recording}, 32'd0);
    sendFrame(16'h1111, 16'h0000, -1, -1, 4'b0000);
    sendFrame(16'h2222, 16'h0000, -1, -1, 4'b0000);
    checkOutput("paused_address", {12'd0, address}, 32'd2);
    applyStimulus(3'b001);
    checkOutput("resume_recording", {31'd0, recording}, 32'd1);
    sendFrame(16'h1234, 16'h0000, 2, -1, 4'b0000);
    checkOutput("resume_length", {12'd0, length}, 32'd3);

    $display("[TB] stop+pause+start during shift");
    sendFrame(16'hC3C3, 16'h0000, -1, 5, 4'b0111);
    checkOutput("stop_shift_recording", {31'd0, recording}, 32'd0);
    checkOutput("stop_shift_length", {12'd0, length}, 32'd3);
    applyStimulus(3'b001);
    checkOutput("clear_address", {12'd0, address}, 32'd0);
    checkOutput("clear_length", {12'd0, length}, 32'd0);

    $display("[TB] fill to ADDR_MAX");
    sendFrame(16'h1001, 16'h0000, 0, -1, 4'b0000);
    sendFrame(16'h2002, 16'h0000, 1, -1, 4'b0000);
    sendFrame(16'h3003, 16'h0000, 2, -1, 4'b0000);
    checkOutput("before_full", {31'd0, full}, 32'd0);
    sendFrame(16'h4004, 16'h0000, 3, -1, 4'b0000);
    sendFrame(16'h5005, 16'h0000, -1, -1, 4'b0000);
    checkOutput("full_flag", {31'd0, full}, 32'd1);
    checkOutput("full_recording", {31'd0, recording}, 32'd0);
    checkOutput("full_length", {12'd0, length}, 32'd4);
    checkOutput("full_address", {12'd0, address}, 32'd3);
    applyStimulus(3'b001);
    checkOutput("full_cleared", {31'd0, full}, 32'd0);

    $display("[TB] reset during shift");
    sendFrame(16'h0F0F, 16'h0000, 0, -1, 4'b0000);
    checkOutput("pre_reset_length", {12'd0, length}, 32'd1);
    sendFrame(16'hFFFF, 16'h0000, -1, 10, 4'b1000);
    checkOutput("post_reset_recording", {31'd0, recording}, 32'd1);
    sendFrame(16'h7E81, 16'h0000, 0, -1, 4'b0000);
    checkOutput("post_reset_length", {12'd0, length}, 32'd1);

    repeat (4) @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
# aud_recorder

Captures left-channel ADC samples from the WM8731 I2S stream and emits one 16-bit SRAM write per audio frame. It sits directly upstream of the SRAM write port in the record path, clocked by AUD_BCLK. Start, pause and stop control come from the top-level controller. Recording halts automatically when the address space is exhausted.

## Interface
- ADDR_MAX, 20'hFFFFF, last writable SRAM address; recording ends after writing it
- i_clk  in  1  AUD_BCLK; all logic on rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_lrc  in  1  AUD_ADCLRCK; low = left channel
- i_data  in  1  AUD_ADCDAT, MSB first
- i_start  in  1  single-cycle pulse: begin or resume recording
- i_pause  in  1  single-cycle pulse: suspend recording, keep address
- i_stop  in  1  single-cycle pulse: end recording
- o_address  out  20  SRAM address for o_data; equals samples stored so far
- o_data  out  16  captured sample, two's complement
- o_valid  out  1  one-cycle write strobe; o_address/o_data valid while high
- o_length  out  20  number of samples stored in this recording
- o_recording  out  1  high in WAIT, SHIFT and STORE
- o_full  out  1  sticky; set when ADDR_MAX has been written

## Operation
- States: IDLE, WAIT, SHIFT, STORE, PAUSE.
- lrc_q is a register of i_lrc. Left edge = (lrc_q==1 && i_lrc==0) at a rising edge.
- IDLE:
  - i_start -> WAIT.
  - On that transition, clear o_address, o_length and o_full.
- WAIT: on a left edge -> SHIFT, with bit counter = 0.
- SHIFT:
  - Each cycle, shift i_data into a 16-bit register (MSB first) and increment the counter.
  - After the 16th bit -> STORE.
  - A right-channel transition is ignored.
- STORE: one cycle.
  - o_valid=1, o_data = shift register, o_address = current address.
  - Next cycle: o_address += 1 and o_length += 1.
  - If the address written == ADDR_MAX: o_full=1 and -> IDLE, with o_address held at ADDR_MAX and o_length = ADDR_MAX+1 (saturate; no wrap).
  - Otherwise -> WAIT.
- PAUSE:
  - i_pause in WAIT or SHIFT -> PAUSE; any partial sample is discarded.
  - In PAUSE, i_start -> WAIT with the address preserved.
- i_stop in any state -> IDLE; any partial sample is discarded; o_address and o_length hold.
- Priority for simultaneous pulses: stop > pause > start.
- i_start in WAIT/SHIFT/STORE and i_pause in IDLE/PAUSE/STORE are ignored.
- A stop or pause arriving in the STORE cycle does not cancel that write: o_valid stays high and o_length counts it.
- o_data holds its last value between strobes.

## Timing
- Reset (asynchronous, any state):
  - State = IDLE, lrc_q=0.
  - All outputs 0: o_address=0, o_data=0, o_valid=0, o_length=0, o_recording=0, o_full=0.
  - Because lrc_q resets to 0, the first capture after reset requires i_lrc to be sampled high, then low.
- I2S one-bit delay, with cycle E = the rising edge that detects the left edge:
  - MSB sampled at E+1, LSB at E+16.
  - o_valid high during cycle E+17.
  - Address/length update visible at E+18.
- Throughput: at most one write per LRC period; frames need ≥ 18 BCLK per LRC half.
- Control pulses take effect on the next rising edge; o_recording follows state one cycle after the pulse.
- Reset mid-SHIFT or mid-STORE: the strobe is dropped immediately; no partial write.

## Test plan
- Left half carries 16'hA55A with lrc toggling every 32 BCLK; pulse i_start.
  - Required: o_valid at E+17 with o_data=16'hA55A, o_address=0.
  - The next frame with 16'h8001 writes at o_address=1; o_length=2.
- Right-half data 16'hFFFF while left = 16'h0000 -> every write has o_data=16'h0000.
- i_pause at bit 8 of a frame, i_start 3 frames later:
  - The partial frame is not written.
  - The next write lands at o_address = previous+1.
  - o_recording=0 while paused.
- i_stop asserted in the same cycle as i_pause and i_start during SHIFT -> IDLE, no write, o_length unchanged. A later i_start from IDLE clears o_address and o_length to 0.
- ADDR_MAX=3: record 5 frames.
  - Exactly 4 writes, to addresses 0..3.
  - Then o_full=1, o_recording=0, o_length=4.
  - The next i_start clears o_full.
- Assert i_rst at bit 10 of SHIFT -> all outputs 0 asynchronously, no o_valid. After release, the first write occurs only after an lrc high->low.
